// File: rtl/burst_line_master_pkg.sv
// Shared definitions for the line-burst master and the burst RAM it drives.
package burst_line_master_pkg;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        RD_COLLECT = 2'd1,
        WR_BEATS   = 2'd2,
        RESP       = 2'd3
    } state_e;

    localparam logic CMD_READ  = 1'b0;
    localparam logic CMD_WRITE = 1'b1;

    // Beat counter width; at least one bit so single-beat builds still elaborate.
    function automatic int unsigned beat_bits(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/burst_line_master.sv
// Converts whole-line client reads/writes into fixed-length bursts on a burst RAM.
module burst_line_master
    import burst_line_master_pkg::*;
#(
    parameter int unsigned BURST_COUNT      = 4,
    parameter int unsigned DATA_BITWIDTH    = 64,
    parameter int unsigned ADDRESS_BITWIDTH = 4
) (
    input  logic                                                   clk,
    input  logic                                                   rst,
    input  logic                                                   req_valid,
    input  logic                                                   req_write,
    input  logic [ADDRESS_BITWIDTH-beat_bits(BURST_COUNT)-1:0]     req_line,
    input  logic [BURST_COUNT*DATA_BITWIDTH-1:0]                   req_wdata,
    input  logic [BURST_COUNT*DATA_BITWIDTH/8-1:0]                 req_wmask,
    output logic                                                   req_ready,
    output logic                                                   resp_valid,
    output logic [BURST_COUNT*DATA_BITWIDTH-1:0]                   resp_rdata,
    output logic                                                   cmd,
    output logic                                                   cmd_en,
    output logic [ADDRESS_BITWIDTH-1:0]                            addr,
    output logic [DATA_BITWIDTH-1:0]                               wr_data,
    output logic [DATA_BITWIDTH/8-1:0]                             data_mask,
    input  logic [DATA_BITWIDTH-1:0]                               rd_data,
    input  logic                                                   rd_data_valid,
    input  logic                                                   busy
);

    localparam int unsigned BEAT_W  = beat_bits(BURST_COUNT);
    localparam int unsigned BMASK_W = DATA_BITWIDTH / 8;
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BURST_COUNT - 1);

    state_e                                     state_q, state_d;
    logic [BEAT_W-1:0]                          beat_q, beat_d;
    // One line buffer serves both as latched write data and as read collection space.
    logic [BURST_COUNT-1:0][DATA_BITWIDTH-1:0]  line_q, line_d;
    logic [BURST_COUNT-1:0][BMASK_W-1:0]        mask_q, mask_d;

    logic                                       cmd_d, cmd_en_d, resp_valid_d;
    logic [ADDRESS_BITWIDTH-1:0]                addr_d;
    logic [DATA_BITWIDTH-1:0]                   wr_data_d;
    logic [BMASK_W-1:0]                         data_mask_d;
    logic [BURST_COUNT*DATA_BITWIDTH-1:0]       resp_rdata_d;
    logic                                       handshake;

    assign req_ready = (state_q == IDLE) && !busy;
    assign handshake = req_valid && req_ready;

    // Next-state and next-output logic.
    always_comb begin
        state_d      = state_q;
        beat_d       = beat_q;
        line_d       = line_q;
        mask_d       = mask_q;
        cmd_d        = cmd;
        cmd_en_d     = 1'b0;
        addr_d       = addr;
        wr_data_d    = wr_data;
        data_mask_d  = data_mask;
        resp_valid_d = 1'b0;
        resp_rdata_d = resp_rdata;

        case (state_q)
            IDLE: begin
                if (handshake) begin
                    cmd_en_d = 1'b1;
                    cmd_d    = req_write ? CMD_WRITE : CMD_READ;
                    addr_d   = {req_line, BEAT_W'(0)};
                    beat_d   = '0;
                    if (req_write) begin
                        line_d       = req_wdata;
                        mask_d       = req_wmask;
                        wr_data_d    = req_wdata[DATA_BITWIDTH-1:0];
                        data_mask_d  = req_wmask[BMASK_W-1:0];
                        beat_d       = BEAT_W'(1);
                        state_d      = (LAST_BEAT == '0) ? RESP : WR_BEATS;
                        resp_valid_d = (LAST_BEAT == '0);
                    end else begin
                        state_d = RD_COLLECT;
                    end
                end
            end
            RD_COLLECT: begin
                if (rd_data_valid) begin
                    line_d[beat_q] = rd_data;
                    beat_d         = beat_q + BEAT_W'(1);
                    if (beat_q == LAST_BEAT) begin
                        resp_rdata_d = line_d;
                        resp_valid_d = 1'b1;
                        state_d      = RESP;
                    end
                end
            end
            WR_BEATS: begin
                wr_data_d   = line_q[beat_q];
                data_mask_d = mask_q[beat_q];
                beat_d      = beat_q + BEAT_W'(1);
                if (beat_q == LAST_BEAT) begin
                    resp_valid_d = 1'b1;
                    state_d      = RESP;
                end
            end
            RESP: begin
                beat_d  = '0;
                state_d = IDLE;
            end
            default: begin
                beat_d  = '0;
                state_d = IDLE;
            end
        endcase
    end

    // State and registered outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            beat_q     <= '0;
            line_q     <= '0;
            mask_q     <= '0;
            cmd        <= CMD_READ;
            cmd_en     <= 1'b0;
            addr       <= '0;
            wr_data    <= '0;
            data_mask  <= '0;
            resp_valid <= 1'b0;
            resp_rdata <= '0;
        end else begin
            state_q    <= state_d;
            beat_q     <= beat_d;
            line_q     <= line_d;
            mask_q     <= mask_d;
            cmd        <= cmd_d;
            cmd_en     <= cmd_en_d;
            addr       <= addr_d;
            wr_data    <= wr_data_d;
            data_mask  <= data_mask_d;
            resp_valid <= resp_valid_d;
            resp_rdata <= resp_rdata_d;
        end
    end

endmodule

// File: tb/tb_burst_line_master.sv
// Scoreboard bench for burst_line_master against a behavioural burst RAM and line-level model.
module tb_burst_line_master;

    localparam int unsigned BC   = 4;
    localparam int unsigned DW   = 64;
    localparam int unsigned AW   = 4;
    localparam int unsigned LINE = BC * DW;
    localparam int unsigned LMW  = LINE / 8;
    localparam int unsigned LAT  = 4;

    logic            clk = 1'b0;
    logic            rst = 1'b0;
    logic            req_valid = 1'b0;
    logic            req_write = 1'b0;
    logic [1:0]      req_line = '0;
    logic [LINE-1:0] req_wdata = '0;
    logic [LMW-1:0]  req_wmask = '0;
    logic            req_ready, resp_valid, cmd, cmd_en;
    logic [LINE-1:0] resp_rdata;
    logic [AW-1:0]   addr;
    logic [DW-1:0]   wr_data;
    logic [DW/8-1:0] data_mask;
    logic [DW-1:0]   rd_data = '0;
    logic            rd_data_valid = 1'b0;
    logic            busy;

    always #5 clk = ~clk;

    burst_line_master #(.BURST_COUNT(BC), .DATA_BITWIDTH(DW), .ADDRESS_BITWIDTH(AW)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_write(req_write),
        .req_line(req_line), .req_wdata(req_wdata), .req_wmask(req_wmask),
        .req_ready(req_ready), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
        .cmd(cmd), .cmd_en(cmd_en), .addr(addr), .wr_data(wr_data), .data_mask(data_mask),
        .rd_data(rd_data), .rd_data_valid(rd_data_valid), .busy(busy)
    );

    function automatic logic [DW-1:0] init_word(input int i);
        case (i)
            0: return 64'h3F5A2E14B7C6A980;
            1: return 64'h9D8E2F17AB4C3E6F;
            2: return 64'hA1C3F7E2D5B8A9C4;
            3: return 64'h7D4E9F2C1B6A3D8F;
            4: return 64'h6C4B9A8D2F5E3C7A;
            5: return 64'hE1A7D0B5C8F3E6A9;
            6: return 64'hF8E9D2C3B4A5F6E7;
            7: return 64'hD4E7F2C5B8A3D6E9;
            default: return 64'hC0DE000000000000 ^ (64'(i) * 64'h9E3779B97F4A7C15);
        endcase
    endfunction

    // Byte-masked merge: a set mask bit leaves the old byte in place.
    function automatic logic [DW-1:0] merge(input logic [DW-1:0] old, input logic [DW-1:0] nw,
                                            input logic [DW/8-1:0] m);
        logic [DW-1:0] r = old;
        for (int b = 0; b < DW / 8; b++)
            if (!m[b]) r[b*8 +: 8] = nw[b*8 +: 8];
        return r;
    endfunction

    // ---------------- behavioural burst RAM ----------------
    logic [DW-1:0] mem [16];
    bit            mem_loaded = 1'b0;
    int            ram_lat = 0, ram_rd_left = 0, ram_wr_left = 0, beats_sent = 0;
    logic [AW-1:0] ram_raddr = '0, ram_waddr = '0;
    bit            force_busy = 1'b0, gaps_en = 1'b0, spurious_en = 1'b0;

    assign busy = force_busy || (ram_rd_left != 0) || (ram_wr_left != 0);

    always @(posedge clk) begin
        rd_data_valid <= 1'b0;
        if (!mem_loaded) begin
            for (int i = 0; i < 16; i++) mem[i] <= init_word(i);
            mem_loaded <= 1'b1;
        end else begin
            if (cmd_en && cmd) begin
                mem[addr]   <= merge(mem[addr], wr_data, data_mask);
                ram_waddr   <= addr + 4'd1;
                ram_wr_left <= BC - 1;
            end else if (ram_wr_left > 0) begin
                mem[ram_waddr] <= merge(mem[ram_waddr], wr_data, data_mask);
                ram_waddr      <= ram_waddr + 4'd1;
                ram_wr_left    <= ram_wr_left - 1;
            end
            if (cmd_en && !cmd) begin
                ram_raddr   <= addr;
                ram_lat     <= LAT;
                ram_rd_left <= BC;
            end else if (ram_rd_left > 0) begin
                if (ram_lat > 0) begin
                    ram_lat <= ram_lat - 1;
                end else if (!gaps_en || $urandom_range(0, 2) != 0) begin
                    rd_data       <= mem[ram_raddr];
                    rd_data_valid <= 1'b1;
                    ram_raddr     <= ram_raddr + 4'd1;
                    ram_rd_left   <= ram_rd_left - 1;
                    beats_sent    <= beats_sent + 1;
                end
            end else if (spurious_en && !req_valid && !cmd_en && $urandom_range(0, 3) == 0) begin
                rd_data       <= {$urandom, $urandom};
                rd_data_valid <= 1'b1;
            end
        end
    end

    // ---------------- reference model and scoreboard ----------------
    typedef struct { bit wr; logic [AW-1:0] a; } cmd_exp_t;
    typedef struct { bit wr; logic [LINE-1:0] data; } resp_exp_t;

    logic [DW-1:0]   ref_mem [16];
    cmd_exp_t        cmd_q[$];
    resp_exp_t       resp_q[$];
    cmd_exp_t        ce;
    resp_exp_t       re;
    int              n_pass = 0, n_total = 0;
    logic [LINE-1:0] last_rd = '0;
    logic [LINE-1:0] last_dut_rd = '0;

    task automatic check(input string name, input logic [LINE-1:0] act, input logic [LINE-1:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h required %h", name, act, exp);
    endtask

    task automatic fail(input string name);
        n_total++;
        $display("FAIL %s: event seen, none required", name);
    endtask

    function automatic logic [LINE-1:0] ref_line(input int l);
        logic [LINE-1:0] r;
        for (int k = 0; k < BC; k++) r[k*DW +: DW] = ref_mem[l*BC + k];
        return r;
    endfunction

    function automatic logic [LINE-1:0] rand_line();
        logic [LINE-1:0] r;
        for (int i = 0; i < LINE / 32; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    task automatic push_exp(input bit wr, input int l, input logic [LINE-1:0] wd, input logic [LMW-1:0] wm);
        cmd_exp_t c;
        resp_exp_t r;
        c.wr = wr;
        c.a  = AW'(l * BC);
        cmd_q.push_back(c);
        if (wr) begin
            for (int k = 0; k < BC; k++)
                ref_mem[l*BC + k] = merge(ref_mem[l*BC + k], wd[k*DW +: DW], wm[k*(DW/8) +: DW/8]);
            r.wr = 1'b1;
            r.data = '0;
        end else begin
            r.wr = 1'b0;
            r.data = ref_line(l);
        end
        resp_q.push_back(r);
    endtask

    // Drive one request, record its expectation at the handshake, then scramble the inputs.
    task automatic issue(input bit wr, input int l, input logic [LINE-1:0] wd, input logic [LMW-1:0] wm);
        int t = 0;
        @(negedge clk);
        req_valid = 1'b1; req_write = wr; req_line = 2'(l); req_wdata = wd; req_wmask = wm;
        #1;
        while (!req_ready && t < 200) begin
            @(negedge clk); #1; t++;
        end
        if (!req_ready) begin
            fail("req_ready timeout");
            req_valid = 1'b0;
            return;
        end
        push_exp(wr, l, wd, wm);
        @(posedge clk); #1;
        req_valid = 1'b0;
        req_wdata = rand_line();
        req_wmask = LMW'($urandom);
        req_line  = 2'($urandom);
    endtask

    task automatic wait_done();
        int t = 0;
        while ((resp_q.size() != 0 || busy) && t < 300) begin
            @(negedge clk); t++;
        end
        if (t >= 300) fail("completion timeout");
    endtask

    // Monitor: every cmd_en and resp_valid must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (rst) begin
            if (cmd_en) begin
                if (cmd_q.size() == 0) fail("unexpected cmd_en");
                else begin
                    ce = cmd_q.pop_front();
                    check("cmd", LINE'(cmd), LINE'(ce.wr));
                    check("addr", LINE'(addr), LINE'(ce.a));
                end
            end
            if (resp_valid) begin
                if (resp_q.size() == 0) fail("unexpected resp_valid");
                else begin
                    re = resp_q.pop_front();
                    if (!re.wr) begin
                        check("read line", resp_rdata, re.data);
                        last_rd     = re.data;
                        last_dut_rd = resp_rdata;
                    end else begin
                        check("rdata hold", resp_rdata, last_rd);
                    end
                end
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL global timeout");
        $fatal(1);
    end

    initial begin
        logic [LINE-1:0] wl;
        logic [LINE-1:0] ones;
        logic [DW-1:0]   orig;
        int              base;
        int              t;

        for (int i = 0; i < 16; i++) ref_mem[i] = init_word(i);
        repeat (3) @(negedge clk);
        check("reset cmd_en", LINE'(cmd_en), '0);
        check("reset resp_valid", LINE'(resp_valid), '0);
        check("reset resp_rdata", resp_rdata, '0);
        check("reset cmd/addr/wdata/mask", LINE'({cmd, addr, wr_data, data_mask}), '0);
        @(negedge clk); #1 rst = 1'b1;

        // Lines 0 and 1 hold known contents.
        issue(1'b0, 0, '0, '0); wait_done();
        issue(1'b0, 1, '0, '0); wait_done();

        // Full-line write with no mask, then read back.
        ones = '0;
        for (int k = 0; k < BC; k++) ones[k*DW +: DW] = {16{4'(k + 1)}};
        issue(1'b1, 2, ones, '0); wait_done();
        issue(1'b0, 2, '0, '0); wait_done();
        check("line2 readback", last_dut_rd, ones);

        // Byte 0 masked off: that byte keeps the old RAM value.
        orig = init_word(12);
        wl = rand_line();
        issue(1'b1, 3, wl, LMW'(1)); wait_done();
        issue(1'b0, 3, '0, '0); wait_done();
        check("masked byte0", LINE'(last_dut_rd[7:0]), LINE'(orig[7:0]));
        check("unmasked byte1", LINE'(last_dut_rd[15:8]), LINE'(wl[15:8]));

        // Busy held high blocks the request.
        force_busy = 1'b1;
        @(negedge clk);
        req_valid = 1'b1; req_write = 1'b0; req_line = 2'd1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk); #1;
            check("busy req_ready", LINE'(req_ready), '0);
            check("busy cmd_en", LINE'(cmd_en), '0);
        end
        force_busy = 1'b0;
        #1;
        check("ready after busy", LINE'(req_ready), LINE'(1));
        push_exp(1'b0, 1, '0, '0);
        @(posedge clk); #1 req_valid = 1'b0;
        wait_done();

        // Reset after beat 2 of a read: burst abandoned, late beats ignored.
        base = beats_sent;
        issue(1'b0, 0, '0, '0);
        t = 0;
        while (beats_sent < base + 3 && t < 100) begin
            @(posedge clk); #1; t++;
        end
        if (beats_sent < base + 3) fail("beat wait timeout");
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        check("abort cmd_en", LINE'(cmd_en), '0);
        check("abort resp_valid", LINE'(resp_valid), '0);
        check("abort resp_rdata", resp_rdata, '0);
        cmd_q.delete();
        resp_q.delete();
        last_rd = '0;
        @(negedge clk); #1 rst = 1'b1;
        repeat (8) begin
            @(negedge clk);
            check("post-reset resp_valid", LINE'(resp_valid), '0);
        end
        wait_done();
        issue(1'b0, 0, '0, '0); wait_done();

        // Randomised traffic with beat gaps and stray rd_data_valid.
        gaps_en = 1'b1;
        spurious_en = 1'b1;
        for (int i = 0; i < 40; i++) begin
            wl = rand_line();
            issue(1'($urandom_range(0, 1)), $urandom_range(0, 3), wl,
                  ($urandom_range(0, 2) == 0) ? '0 : LMW'($urandom));
            wait_done();
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end
        gaps_en = 1'b0;
        spurious_en = 1'b0;
        for (int l = 0; l < 4; l++) begin
            issue(1'b0, l, '0, '0); wait_done();
        end

        repeat (5) @(negedge clk);
        if (cmd_q.size() != 0 || resp_q.size() != 0) fail("outstanding expectations");
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
